hex_scan_display: RTL and testbench
===================================

// Module: hex_scan_display
// PURPOSE
//  Parametrised, time-multiplexed 7-segment driver for the core demo board; successor of the fixed 8-digit hex output stage.
//  Scans N_DIGITS hex digits and applies a per-digit enable mask, per-digit decimal points and optional leading-zero blanking.
//  New data is loaded through a one-cycle handshake and committed only at frame boundaries, so the display never tears.
//  Sits between the core's display/MMIO register and the board pins (hex_o, dp_o, an_o).
// PARAMETERS
//  N_DIGITS        8      number of digits scanned (1..16)
//  SCAN_DIV        1000   clk_i cycles each digit is driven (>=2)
//  ACTIVE_LOW      1      1: an_o/hex_o/dp_o active-low (board default); 0: active-high
//  LZ_BLANK        0      1: blank leading zeros above the most significant non-zero digit
// PORTS
//  clk_i        in   1            system clock
//  rst_i        in   1            synchronous reset, active-high
//  data_i       in   4*N_DIGITS   hex nibbles; digit k = data_i[4k+3:4k], digit 0 rightmost
//  dp_i         in   N_DIGITS     decimal-point request per digit, captured with data_i
//  en_i         in   N_DIGITS     digit enable mask, live (not shadowed); 0 = anode off
//  load_i       in   1            1-cycle strobe: capture data_i/dp_i into shadow
//  pending_o    out  1            shadow holds data not yet committed to display
//  frame_o      out  1            1-cycle pulse, one per completed scan frame
//  hex_o        out  7            segments {g,f,e,d,c,b,a}; hex_o[0] = a
//  dp_o         out  1            decimal point of current digit
//  an_o         out  N_DIGITS     anode select, one-hot (active level per ACTIVE_LOW)
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): prescaler=0, idx=0, shadow=0, disp=0, pending_o=0, frame_o=0;
//   an_o, hex_o and dp_o all inactive (all 1 if ACTIVE_LOW). rst_i overrides load_i; a mid-frame reset discards pending data.
//  Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler==SCAN_DIV-1).
//  On tick: idx <= (idx==N_DIGITS-1) ? 0 : idx+1. wrap = tick && idx==N_DIGITS-1.
//  On wrap: frame_o=1 in the next cycle (exactly one cycle); if pending, disp <= shadow and pending clears.
//  load_i: shadow <= {dp_i,data_i}; pending_o=1 from the next cycle. Repeated loads before commit: last wins.
//  load_i in a wrap cycle: old shadow is committed, new data is captured, pending_o stays 1 and commits at the next wrap.
//  Outputs are registered from idx/disp/en_i: latency 1 cycle. an_o selects digit k from the cycle after idx becomes k.
//  Blanking (anode off, segments/dp inactive): en_i[idx]=0; or LZ_BLANK=1, idx>0 and every nibble at index >= idx is 0.
//  Digit 0 is never zero-blanked. dp is not blanked by LZ unless the digit itself is blanked.
//  Encoding (active-high {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71;
//   ACTIVE_LOW inverts hex_o, dp_o and an_o.
//  Exactly one anode is active per cycle after reset release, except when the digit is blanked (none active).
// TESTING
//  (N_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1 unless stated otherwise)
//  1 Reset: hold rst_i 3 cycles with load_i=1 -> an_o=4'hF, hex_o=7'h7F, dp_o=1, pending_o=0, frame_o=0 throughout.
//  2 Load 16'h12AF, dp_i=4'b0010, en_i=4'hF mid-frame -> pending_o=1 until first wrap; frame_o pulses one cycle, then an_o cycles
//    E,D,B,7 every 4 clocks with hex_o ~71,~77,~5B,~06; dp_o=0 only for digit 1; frame_o period = 16 clocks.
//  3 Two loads (16'h1111 then 16'h2222) before a wrap, plus a third load on the wrap cycle itself -> 2222 is displayed,
//    pending_o stays 1, and the third value appears one frame later.
//  4 LZ_BLANK=1, data 16'h0050 -> digits 3 and 2 show an_o=F (blank), digit 1 shows ~6D, digit 0 shows ~3F;
//    data 16'h0000 -> only digit 0 lit, showing ~3F.
//  5 en_i=4'b1010 -> anodes 0 and 2 never active, and their slots output hex_o=7F; toggling en_i takes effect within 1 cycle
//    without waiting for a wrap.
//  6 Assert rst_i for 1 cycle while pending_o=1 mid-frame -> outputs inactive the next cycle, pending_o=0, scan restarts
//    at digit 0 showing 0.

Source files
------------

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex 7-segment scanner with frame-aligned shadow commit,
// per-digit enable mask, decimal points and optional leading-zero blanking.
module hex_scan_display #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned LZ_BLANK   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*N_DIGITS-1:0]   data_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic [N_DIGITS-1:0]     en_i,
    input  logic                    load_i,
    output logic                    pending_o,
    output logic                    frame_o,
    output logic [6:0]              hex_o,
    output logic                    dp_o,
    output logic [N_DIGITS-1:0]     an_o
);

    localparam int unsigned       PS_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned       IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic              INV      = (ACTIVE_LOW != 0);

    logic [PS_W-1:0]       prescaler;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [4*N_DIGITS-1:0] disp_data;
    logic [N_DIGITS-1:0]   disp_dp;
    logic                  tick;
    logic                  wrap;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  cur_lz;
    logic                  upper_zero;
    logic                  blank;
    logic [N_DIGITS-1:0]   an_hi;
    logic [6:0]            seg_hi;
    logic                  dp_hi;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Walk digits from the top down so upper_zero means "this and every higher nibble is 0".
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_lz     = 1'b0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            upper_zero = upper_zero && (disp_data[4*(N_DIGITS-1-i) +: 4] == 4'h0);
            if (idx == IDX_W'(N_DIGITS - 1 - i)) begin
                cur_nib = disp_data[4*(N_DIGITS-1-i) +: 4];
                cur_dp  = disp_dp[N_DIGITS-1-i];
                cur_en  = en_i[N_DIGITS-1-i];
                cur_lz  = upper_zero;
            end
        end
    end

    always_comb begin
        blank  = !cur_en || ((LZ_BLANK != 0) && (idx != '0) && cur_lz);
        an_hi  = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            an_hi[k] = !blank && (idx == IDX_W'(k));
        end
        seg_hi = blank ? 7'h00 : seg_decode(cur_nib);
        dp_hi  = !blank && cur_dp;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescaler   <= '0;
            idx         <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            pending_o   <= 1'b0;
            frame_o     <= 1'b0;
            an_o        <= {N_DIGITS{INV}};
            hex_o       <= {7{INV}};
            dp_o        <= INV;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            frame_o <= wrap;
            // Commit reads the old shadow, so a load landing on the wrap cycle stays pending.
            if (wrap && pending_o) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
            end
            if (load_i) begin
                shadow_data <= data_i;
                shadow_dp   <= dp_i;
            end
            pending_o <= load_i || (pending_o && !wrap);
            an_o      <= an_hi ^ {N_DIGITS{INV}};
            hex_o     <= seg_hi ^ {7{INV}};
            dp_o      <= dp_hi ^ INV;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display (4 digits, 4-cycle scan, active-low),
// run side by side on a plain instance and a leading-zero-blanking instance.
module tb_hex_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;

    logic        pend, frame, dpo;
    logic [6:0]  hex;
    logic [3:0]  an;
    logic        pend_lz, frame_lz, dpo_lz;
    logic [6:0]  hex_lz;
    logic [3:0]  an_lz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_scan_display #(.N_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(0)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .dp_i(dp), .en_i(en), .load_i(load),
        .pending_o(pend), .frame_o(frame), .hex_o(hex), .dp_o(dpo), .an_o(an)
    );

    hex_scan_display #(.N_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_lz (
        .clk_i(clk), .rst_i(rst), .data_i(data), .dp_i(dp), .en_i(en), .load_i(load),
        .pending_o(pend_lz), .frame_o(frame_lz), .hex_o(hex_lz), .dp_o(dpo_lz), .an_o(an_lz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_digit(input string tag, input bit lz, input logic [3:0] an_e,
                               input logic [6:0] hex_e, input logic dp_e);
        check({tag, "_an"},  lz ? an_lz  : an,  an_e);
        check({tag, "_hex"}, lz ? hex_lz : hex, hex_e);
        check({tag, "_dp"},  lz ? dpo_lz : dpo, dp_e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [3:0] an_tab [4];
        logic [6:0] hex_tab [4];
        int         n;
        bit         found;

        // Reset overrides an active load
        rst = 1'b1; load = 1'b1; data = 16'h1234; dp = 4'hF; en = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_digit("rst", 0, 4'hF, 7'h7F, 1'b1);
            check_digit("rst_lz", 1, 4'hF, 7'h7F, 1'b1);
            check("rst_pend", pend, 0);
            check("rst_frame", frame, 0);
            check("rst_pend_lz", pend_lz, 0);
        end
        rst = 1'b0; load = 1'b0; data = '0; dp = '0;

        // E1: digit 0 of the reset display contents
        step();
        check("e1_pend", pend, 0);
        check_digit("e1", 0, 4'hE, ~7'h3F, 1'b1);

        // Mid-frame load at E6, first wrap expected at E16
        steps(4);
        load = 1'b1; data = 16'h12AF; dp = 4'b0010;
        step();
        load = 1'b0;
        check("load_pend", pend, 1);
        n = 6;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            n++;
            if (frame === 1'b1) found = 1;
            else check("pend_hold", pend, 1);
        end
        check("first_frame_edge", n, 16);
        check("commit_pend", pend, 0);

        an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
        hex_tab = '{7'h0E, 7'h08, 7'h24, 7'h79};
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check_digit("scan", 0, an_tab[d], hex_tab[d], (d == 1) ? 1'b0 : 1'b1);
                check("scan_frame", frame, (d == 3 && c == 3) ? 1 : 0);
            end
        end

        // Now at E32: two loads, then a load landing on the E48 wrap
        steps(2);
        load = 1'b1; data = 16'h1111; dp = 4'h0;
        step();
        data = 16'h2222;
        step();
        load = 1'b0;
        check("dbl_pend", pend, 1);
        steps(11);
        load = 1'b1; data = 16'h3456;
        step();
        load = 1'b0;
        check("wrap_load_frame", frame, 1);
        check("wrap_load_pend", pend, 1);
        step();
        check_digit("last_wins", 0, 4'hE, ~7'h5B, 1'b1);
        steps(15);
        check("third_frame", frame, 1);
        check("third_pend", pend, 0);
        step();
        check_digit("third_val", 0, 4'hE, ~7'h7D, 1'b1);

        // E65: enable mask 1010 acts immediately
        en = 4'b1010;
        for (int i = 1; i < 16; i++) begin
            logic [3:0] ea;
            logic [6:0] eh;
            step();
            case (i / 4)
                1:       begin ea = 4'hD; eh = ~7'h6D; end
                3:       begin ea = 4'h7; eh = ~7'h4F; end
                default: begin ea = 4'hF; eh = 7'h7F;  end
            endcase
            check_digit("mask", 0, ea, eh, 1'b1);
        end
        step();
        check_digit("mask_d0", 0, 4'hF, 7'h7F, 1'b1);
        en = 4'hF;
        step();
        check_digit("unmask", 0, 4'hE, ~7'h7D, 1'b1);

        // E82: leading-zero blanking of 0050 on the LZ instance
        load = 1'b1; data = 16'h0050;
        step();
        load = 1'b0;
        steps(13);
        check("lz_frame", frame_lz, 1);
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] ea;
            logic [6:0] eh;
            step();
            case ((i - 1) / 4)
                0:       begin ea = 4'hE; eh = ~7'h3F; end
                1:       begin ea = 4'hD; eh = ~7'h6D; end
                default: begin ea = 4'hF; eh = 7'h7F;  end
            endcase
            check_digit("lz50", 1, ea, eh, 1'b1);
            if ((i - 1) / 4 == 3) check_digit("nolz50", 0, 4'h7, ~7'h3F, 1'b1);
        end

        // E112: all-zero data, only digit 0 lit
        load = 1'b1; data = 16'h0000;
        step();
        load = 1'b0;
        steps(15);
        check("lz0_frame", frame_lz, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if ((i - 1) / 4 == 0) check_digit("lz00", 1, 4'hE, ~7'h3F, 1'b1);
            else                  check_digit("lz00", 1, 4'hF, 7'h7F, 1'b1);
        end

        // E144: pending data discarded by a mid-frame reset
        load = 1'b1; data = 16'hBEEF; dp = 4'hF;
        step();
        load = 1'b0;
        steps(5);
        check("pre_rst_pend", pend, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_digit("midrst", 0, 4'hF, 7'h7F, 1'b1);
        check("midrst_pend", pend, 0);
        check("midrst_frame", frame, 0);
        step();
        check_digit("restart", 0, 4'hE, ~7'h3F, 1'b1);
        check("restart_pend", pend, 0);
        steps(15);
        check("restart_frame", frame, 1);
        step();
        check_digit("discarded", 0, 4'hE, ~7'h3F, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
